// File: rtl/intr_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// claim word layout and FSM states.
package intr_ctrl_pkg;
    localparam int ID_W          = 5;
    localparam int CLAIM_VLD_BIT = 31;

    localparam logic [2:0] ADDR_RAW      = 3'd0;
    localparam logic [2:0] ADDR_PENDING  = 3'd1;
    localparam logic [2:0] ADDR_ENABLE   = 3'd2;
    localparam logic [2:0] ADDR_EDGE     = 3'd3;
    localparam logic [2:0] ADDR_CLAIM    = 3'd4;
    localparam logic [2:0] ADDR_COMPLETE = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        SERVICE = 2'd2
    } state_t;
endpackage

// File: rtl/intr_ctrl_if.sv
// Avalon-MM style register port: single-cycle strobes, registered read data.
interface intr_ctrl_if;
    logic [2:0]  addr;
    logic        read;
    logic        write;
    logic [31:0] wrdata;
    logic [31:0] rddata;

    modport master (output addr, read, write, wrdata, input  rddata);
    modport slave  (input  addr, read, write, wrdata, output rddata);
endinterface

// File: rtl/intr_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module intr_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  id
);
    always_comb begin
        valid = |req;
        id    = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronized sticky pending bits, enable/edge masks,
// fixed-priority claim/complete FSM driving a single registered irq.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_INTR = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_INTR-1:0] interrupt_in,
    intr_ctrl_if.slave          bus,
    output logic                irq
);
    logic [NUM_INTR-1:0] sync1, sync2, prev;
    logic [NUM_INTR-1:0] pending, enable, edge_sel;
    logic [NUM_INTR-1:0] set_vec, clr_vec, pending_nxt, eligible;
    logic [ID_W-1:0]     win_id, claimed_id;
    logic                win_vld, claim, complete;
    logic [31:0]         rd_mux;
    state_t              state;

    assign eligible = pending & enable;

    intr_prio_enc #(.WIDTH(NUM_INTR)) u_prio (
        .req   (eligible),
        .valid (win_vld),
        .id    (win_id)
    );

    assign claim    = bus.read && (bus.addr == ADDR_CLAIM) && (state == ACTIVE) && win_vld;
    assign complete = bus.write && (bus.addr == ADDR_COMPLETE) && (state == SERVICE)
                      && (bus.wrdata[ID_W-1:0] == claimed_id);

    // Set is applied after clears so a same-cycle capture survives a W1C or claim.
    always_comb begin
        set_vec = (sync2 & ~edge_sel) | (sync2 & ~prev & edge_sel);
        clr_vec = '0;
        if (bus.write && bus.addr == ADDR_PENDING) clr_vec = bus.wrdata[NUM_INTR-1:0];
        if (claim) clr_vec = clr_vec | (NUM_INTR'(1) << win_id);
        pending_nxt = (pending & ~clr_vec) | set_vec;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_RAW:     rd_mux = 32'(sync2);
            ADDR_PENDING: rd_mux = 32'(pending);
            ADDR_ENABLE:  rd_mux = 32'(enable);
            ADDR_EDGE:    rd_mux = 32'(edge_sel);
            ADDR_CLAIM: begin
                if (claim) begin
                    rd_mux[CLAIM_VLD_BIT] = 1'b1;
                    rd_mux[ID_W-1:0]      = win_id;
                end
            end
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            pending    <= '0;
            enable     <= '0;
            edge_sel   <= '0;
            bus.rddata <= '0;
        end else begin
            sync1      <= interrupt_in;
            sync2      <= sync1;
            prev       <= sync2;
            pending    <= pending_nxt;
            if (bus.write && bus.addr == ADDR_ENABLE) enable   <= bus.wrdata[NUM_INTR-1:0];
            if (bus.write && bus.addr == ADDR_EDGE)   edge_sel <= bus.wrdata[NUM_INTR-1:0];
            bus.rddata <= bus.read ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq        <= 1'b0;
            claimed_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state <= ACTIVE;
                        irq   <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (claim) begin
                        state      <= SERVICE;
                        irq        <= 1'b0;
                        claimed_id <= win_id;
                    end else if (!win_vld) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (complete) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end
endmodule
